gate_pattern_sequencer: RTL and testbench
=========================================

// Module: gate_pattern_sequencer
// PURPOSE
//  Self-checking stimulus/response stage for 2-input combinational gates (or_gate, and_gate, ...).
//  On start, drives all 4 input vectors (ab = 00,01,10,11) into the gate under test.
//  Holds each vector HOLD cycles, samples the gate output and compares it with the selected op.
//  Reports error count, first failing vector and pass/done. Replaces hand-timed #10 benches with synthesizable logic.
// PARAMETERS
//  HOLD   10  cycles each vector is held before sampling (legal >= 1)
//  CNT_W  4   width of hold counter; must satisfy 2**CNT_W >= HOLD
// PORTS
//  clk          in   1  single clock, all logic on rising edge
//  rst_n        in   1  synchronous, active-low reset
//  start        in   1  pulse/level; sampled only in IDLE
//  op           in   2  expected function: 00 AND, 01 OR, 10 XOR, 11 NAND; latched on start
//  a            out  1  gate operand a (registered)
//  b            out  1  gate operand b (registered)
//  c            in   1  gate output, sampled on last hold cycle
//  busy         out  1  high while sequencing vectors
//  done         out  1  one-cycle pulse at end of run
//  pass         out  1  valid from done until next start; 1 = zero mismatches
//  err_count    out  3  mismatches in last run (0..4)
//  first_fail   out  2  vector index {a,b} of first mismatch; 0 if none
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; a,b,busy,done,pass,err_count,first_fail,vec,hold_cnt=0; op_q=00.
//  Reset wins over everything, including mid-run; a run cut by reset leaves no result.
//  FSM states IDLE, DRIVE, FINISH.
//  IDLE: start=1 -> op_q<=op, vec<=0, hold_cnt<=0, err_count<=0, first_fail<=0, pass<=0, busy<=1, state<=DRIVE.
//  DRIVE: {a,b} = vec (registered, so new vector visible the cycle after it is chosen).
//   hold_cnt increments each cycle. At hold_cnt==HOLD-1, c is sampled vs expected(op_q,a,b).
//   On mismatch: err_count++; if err_count==0, first_fail<=vec.
//   Same edge: if vec==3 -> state<=FINISH, busy<=0; else vec++, hold_cnt<=0.
//  FINISH: done=1 for exactly one cycle; pass<=(err_count==0); state<=IDLE. a,b return to 0.
//  Latency: start seen at edge E0 -> done high in cycle after edge E0+4*HOLD; busy high 4*HOLD cycles.
//  HOLD=1: sample on same cycle vector is applied (c assumed combinational, settles within one cycle).
//  start while busy or in FINISH: ignored, no restart, no error.
//  start held high continuously: a new run begins each time IDLE is re-entered (back-to-back runs legal).
//  op changes mid-run: ignored (op_q used).
//  err_count saturates naturally at 4 (3 bits); no wrap.
//  Expected: AND a&b, OR a|b, XOR a^b, NAND ~(a&b).
// STRUCTURE
//  gate_test_pkg: localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11.
//   Also state encodings S_IDLE, S_DRIVE, S_FINISH and NUM_VEC=4.
//  Sub-module gate_expected_model (combinational): inputs op, a, b -> exp. Reused by other gate benches.
//  Top: FSM, vec/hold counters, compare/score registers.
// TESTING (bench wires a real or_gate / and_gate instance to a,b,c)
//  1. rst_n=0 2 cycles, start=1 held -> all outputs 0, state stays IDLE until release.
//  2. op=01, c from or_gate, HOLD=10, start pulse -> done at E0+40.
//     Vectors 00,01,10,11 seen on a,b; pass=1, err_count=0.
//  3. op=00 (AND) with or_gate -> mismatches at vectors 01,10 -> err_count=2, first_fail=01, pass=0.
//  4. op=11 (NAND) with or_gate -> mismatches at 00,11 -> err_count=2, first_fail=00.
//  5. start re-pulsed mid-run and op flipped -> ignored; result matches original op. done single-cycle.
//  6. rst_n low during vector 2 -> next edge IDLE, outputs 0.
//     New run after release -> clean result, err_count restarts at 0.

Source files
------------

// File: rtl/gate_pattern_sequencer_pkg.sv
// gate_pattern_sequencer_pkg: shared op codes, FSM states and vector count for 2-input gate checkers
package gate_pattern_sequencer_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;
    localparam int NUM_VEC = 4;
    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_t;
endpackage

// File: rtl/gate_pattern_sequencer_expected.sv
// gate_expected_model: reference output of a 2-input gate for the selected op
module gate_expected_model
    import gate_pattern_sequencer_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       expected
);
    always_comb expected = op == OP_AND ? (a & b) :
                           op == OP_OR  ? (a | b) :
                           op == OP_XOR ? (a ^ b) : ~(a & b);
endmodule

// File: rtl/gate_pattern_sequencer.sv
// gate_pattern_sequencer: drives all four {a,b} vectors into a gate, holds each HOLD cycles,
// scores the sampled output against op and reports error count, first failing vector and pass.
module gate_pattern_sequencer
    import gate_pattern_sequencer_pkg::*;
#(
    parameter int HOLD  = 10,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail
);
    state_t state;
    logic [1:0] vec;
    logic [1:0] op_q;
    logic [CNT_W-1:0] hold_cnt;
    logic expected;
    logic sample;
    logic mismatch;

    gate_expected_model u_expected (.op(op_q), .a(a), .b(b), .expected(expected));

    assign sample   = hold_cnt == CNT_W'(HOLD - 1);
    assign mismatch = sample && (c != expected);

    // a,b are loaded together with vec so the sampled operands always match the vector being scored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            vec        <= '0;
            hold_cnt   <= '0;
            op_q       <= OP_AND;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_q       <= op;
                    vec        <= '0;
                    hold_cnt   <= '0;
                    err_count  <= '0;
                    first_fail <= '0;
                    pass       <= 1'b0;
                    busy       <= 1'b1;
                    a          <= 1'b0;
                    b          <= 1'b0;
                    state      <= S_DRIVE;
                end
                S_DRIVE: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (sample) begin
                        if (mismatch) begin
                            err_count <= err_count + 3'd1;
                            if (err_count == 3'd0) first_fail <= vec;
                        end
                        if (vec == LAST_VEC) begin
                            state <= S_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == 3'd0) && !mismatch;
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            vec      <= vec + 2'd1;
                            hold_cnt <= '0;
                            {a, b}   <= vec + 2'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_pattern_sequencer.sv
// tb_gate_pattern_sequencer: scoreboard bench driving the sequencer against an OR or AND gate
module tb_gate_pattern_sequencer;
    localparam int HOLD = 10;

    typedef struct packed {
        logic [2:0] err;
        logic [1:0] ff;
        logic       ps;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [1:0] op = 2'b00;
    logic a, b, c;
    logic busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] first_fail;
    logic use_and = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] vec_q[$];
    res_t res_q[$];
    int time_q[$];

    always #5 clk = ~clk;

    assign c = use_and ? (a & b) : (a | b);

    gate_pattern_sequencer #(.HOLD(HOLD), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_fail(first_fail)
    );

    function automatic logic ref_gate(input logic [1:0] f, input logic [1:0] v);
        case (f)
            2'b00:   return v[1] & v[0];
            2'b01:   return v[1] | v[0];
            2'b10:   return v[1] ^ v[0];
            default: return !(v[1] & v[0]);
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        op = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, pass, err_count, first_fail, a, b} !== 10'd0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0", i, {busy, done, pass, err_count, first_fail, a, b});
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic run_check(input logic [1:0] run_op, input logic and_gate, input bit disturb);
        logic [2:0] e_err = 3'd0;
        logic [1:0] e_ff = 2'd0;
        logic [1:0] ev;
        res_t r;
        use_and = and_gate;
        for (int v = 0; v < 4; v++) begin
            ev = 2'(v);
            if ((and_gate ? (ev[1] & ev[0]) : (ev[1] | ev[0])) != ref_gate(run_op, ev)) begin
                if (e_err == 3'd0) e_ff = ev;
                e_err++;
            end
            vec_q.push_back(ev);
        end
        res_q.push_back('{err: e_err, ff: e_ff, ps: (e_err == 3'd0)});
        op = run_op;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4 * HOLD; i++) begin
            if (disturb && i == 15) begin
                start = 1'b1;
                op = ~run_op;
            end
            if (disturb && i == 16) start = 1'b0;
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL run_busy i=%0d busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            if (i % HOLD == 0) begin
                n_cmp++;
                if (vec_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL run_vec_queue_empty i=%0d", i);
                end else begin
                    ev = vec_q.pop_front();
                    if ({a, b} !== ev) begin
                        n_bad++;
                        $display("FAIL run_vector i=%0d ab=%b want=%b", i, {a, b}, ev);
                    end
                end
            end
            @(negedge clk);
        end
        r = res_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || {a, b} !== 2'b00) begin
            n_bad++;
            $display("FAIL run_done done=%b busy=%b ab=%b want 1,0,00", done, busy, {a, b});
        end
        n_cmp++;
        if ({err_count, first_fail, pass} !== r) begin
            n_bad++;
            $display("FAIL run_result op=%b err=%0d ff=%0d pass=%b want err=%0d ff=%0d pass=%b",
                     run_op, err_count, first_fail, pass, r.err, r.ff, r.ps);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || pass !== r.ps || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL run_after done=%b pass=%b busy=%b want 0,%b,0", done, pass, busy, r.ps);
        end
        op = run_op;
    endtask

    task automatic test_mid_reset;
        use_and = 1'b0;
        op = 2'b00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2 * HOLD + 3; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, pass, err_count, first_fail, a, b} !== 10'd0) begin
            n_bad++;
            $display("FAIL mid_reset got=%b want=0", {busy, done, pass, err_count, first_fail, a, b});
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_check(2'b01, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        use_and = 1'b0;
        op = 2'b01;
        time_q.push_back(4 * HOLD);
        time_q.push_back(8 * HOLD + 2);
        start = 1'b1;
        for (int j = 0; j <= 100; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n_cmp++;
                if (time_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra_done at=%0d", j);
                end else if (time_q[0] != j) begin
                    n_bad++;
                    $display("FAIL b2b_done_time at=%0d want=%0d", j, time_q.pop_front());
                end else begin
                    void'(time_q.pop_front());
                end
                n_cmp++;
                if (err_count !== 3'd0 || pass !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_result err=%0d pass=%b want 0,1", err_count, pass);
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (time_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_missing_done left=%0d want=0", time_q.size());
        end
        for (int k = 0; k < 5 * HOLD && busy === 1'b1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_settle busy=%b want=0", busy);
        end
    endtask

    initial begin
        test_reset();
        run_check(2'b01, 1'b0, 1'b0);
        run_check(2'b00, 1'b0, 1'b0);
        run_check(2'b11, 1'b0, 1'b0);
        run_check(2'b10, 1'b0, 1'b0);
        run_check(2'b00, 1'b1, 1'b0);
        run_check(2'b01, 1'b0, 1'b1);
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
